// File: rtl/sr_omega_slew_limiter.sv
// sr_omega_slew_limiter
// Ramps each packed OMEGA_DT output toward its target by at most SLEW_STEP per
// slew tick. A sweep updates one harmonic per clk so the oscillators never see
// a frequency step larger than SLEW_STEP.
// Optional macro SR_SLEW_CLAMP_EN: clamp targets to [OMEGA_MIN, OMEGA_MAX] on
// load/capture and report any clamp on the sticky clamp_hit flag.
module sr_omega_slew_limiter #(
   parameter int WIDTH         = 18,
   parameter int NUM_HARMONICS = 5,
   parameter int SLEW_STEP     = 1,
   parameter int SLEW_DIV      = 4,
   parameter int OMEGA_MIN     = 150,
   parameter int OMEGA_MAX     = 900
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clk_en,
   input  logic [NUM_HARMONICS*WIDTH-1:0] omega_target_packed,
   output logic [NUM_HARMONICS*WIDTH-1:0] omega_out_packed,
   output logic [NUM_HARMONICS-1:0]       settled,
   output logic                           all_settled,
   output logic                           sweep_busy,
   output logic                           clamp_hit
);

   localparam int IDX_W = (NUM_HARMONICS > 1) ? $clog2(NUM_HARMONICS) : 1;
   localparam int DIV_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
   localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_HARMONICS - 1);
   localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(SLEW_DIV - 1);
   localparam logic signed [WIDTH:0]   STEP_WIDE = (WIDTH+1)'(SLEW_STEP);
   localparam logic signed [WIDTH-1:0] STEP_OUT  = WIDTH'(SLEW_STEP);

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_CAPTURE,
      S_SWEEP
   } state_t;

   state_t                  r_state;
   logic [DIV_W-1:0]        r_div;
   logic                    r_pending;
   logic [IDX_W-1:0]        r_idx;
   logic [NUM_HARMONICS-1:0] r_settled;
   logic                    r_busy;
   logic signed [WIDTH-1:0] r_out    [NUM_HARMONICS];
   logic signed [WIDTH-1:0] r_shadow [NUM_HARMONICS];

   logic signed [WIDTH-1:0] w_tgt [NUM_HARMONICS];
   logic                    w_clamp_any;
   logic                    w_tick;
   logic signed [WIDTH-1:0] w_cur_out;
   logic signed [WIDTH-1:0] w_cur_shadow;
   logic signed [WIDTH:0]   w_diff;
   logic signed [WIDTH-1:0] w_next_out;

`ifdef SR_SLEW_CLAMP_EN
   localparam logic signed [WIDTH-1:0] OMIN = WIDTH'(OMEGA_MIN);
   localparam logic signed [WIDTH-1:0] OMAX = WIDTH'(OMEGA_MAX);

   logic r_clamp_hit;
`endif

   // Unpack the targets and, when clamping is built in, bound them
   always_comb begin
      logic signed [WIDTH-1:0] v_t;
      w_clamp_any = 1'b0;
      for (int unsigned h = 0; h < NUM_HARMONICS; h++) begin
         v_t = omega_target_packed[h*WIDTH +: WIDTH];
`ifdef SR_SLEW_CLAMP_EN
         if (v_t < OMIN) begin
            v_t         = OMIN;
            w_clamp_any = 1'b1;
         end else if (v_t > OMAX) begin
            v_t         = OMAX;
            w_clamp_any = 1'b1;
         end
`endif
         w_tgt[h] = v_t;
      end
   end

   assign w_tick = clk_en && (r_state != S_INIT) && (r_div == DIV_LAST);

   // Slew step for the harmonic currently addressed by the sweep
   always_comb begin
      w_cur_out    = r_out[r_idx];
      w_cur_shadow = r_shadow[r_idx];
      // One extra bit so the difference of two full-range values cannot wrap
      w_diff       = {w_cur_shadow[WIDTH-1], w_cur_shadow} - {w_cur_out[WIDTH-1], w_cur_out};
      if (w_diff > STEP_WIDE) begin
         w_next_out = w_cur_out + STEP_OUT;
      end else if (w_diff < -STEP_WIDE) begin
         w_next_out = w_cur_out - STEP_OUT;
      end else begin
         w_next_out = w_cur_shadow;
      end
   end

   // Prescaler: counts clk_en pulses once the initial load has happened
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
      end else if (clk_en && (r_state != S_INIT)) begin
         r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
      end
   end

   // Sweep FSM: initial load, tick capture, one-harmonic-per-clk slew
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_INIT;
         r_pending <= 1'b0;
         r_idx     <= '0;
         r_settled <= '0;
         r_busy    <= 1'b0;
`ifdef SR_SLEW_CLAMP_EN
         r_clamp_hit <= 1'b0;
`endif
         for (int unsigned h = 0; h < NUM_HARMONICS; h++) begin
            r_out[h]    <= '0;
            r_shadow[h] <= '0;
         end
      end else begin
         case (r_state)
            S_INIT: begin
               if (clk_en) begin
                  for (int unsigned h = 0; h < NUM_HARMONICS; h++) begin
                     r_out[h]    <= w_tgt[h];
                     r_shadow[h] <= w_tgt[h];
                  end
                  r_settled <= '1;
`ifdef SR_SLEW_CLAMP_EN
                  if (w_clamp_any) r_clamp_hit <= 1'b1;
`endif
                  r_state <= S_IDLE;
               end
            end
            S_IDLE: begin
               // A fresh tick and a pending one together start a single sweep
               if (w_tick || r_pending) begin
                  r_pending <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               for (int unsigned h = 0; h < NUM_HARMONICS; h++) begin
                  r_shadow[h] <= w_tgt[h];
               end
`ifdef SR_SLEW_CLAMP_EN
               if (w_clamp_any) r_clamp_hit <= 1'b1;
`endif
               if (w_tick) r_pending <= 1'b1;
               r_idx   <= '0;
               r_state <= S_SWEEP;
            end
            S_SWEEP: begin
               r_out[r_idx]     <= w_next_out;
               r_settled[r_idx] <= (w_next_out == w_cur_shadow);
               if (w_tick) r_pending <= 1'b1;
               if (r_idx == LAST_IDX) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

   // Repack the registered outputs
   always_comb begin
      omega_out_packed = '0;
      for (int unsigned h = 0; h < NUM_HARMONICS; h++) begin
         omega_out_packed[h*WIDTH +: WIDTH] = r_out[h];
      end
   end

   assign settled     = r_settled;
   assign all_settled = &r_settled;
   assign sweep_busy  = r_busy;

`ifdef SR_SLEW_CLAMP_EN
   assign clamp_hit = r_clamp_hit;
`else
   // Clamp bounds only matter with clamping built in; referenced here so both
   // builds share one parameter list
   localparam bit CLAMP_RANGE_OK = (OMEGA_MIN <= OMEGA_MAX);
   assign clamp_hit = 1'b0 && CLAMP_RANGE_OK;
`endif

endmodule
